// File: rtl/sd_reg_master.sv
// Word-level register master: turns WRITE/READ/POLL word requests into byte-wide
// accesses on a simple register-slave bus (we/addr/data_out, combinational data_in).
module sd_reg_master #(
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        we,
  output logic [6:0]  addr,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWr   = 3'd1;
  localparam logic [2:0] StRd   = 3'd2;
  localparam logic [2:0] StChk  = 3'd3;
  localparam logic [2:0] StRsp  = 3'd4;

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpPoll  = 2'b10;

  logic [2:0]  state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  waddr_q, waddr_d;
  // WRITE: data still to be sent, MSB-aligned; POLL: the mask.
  logic [31:0] wdata_q, wdata_d;
  // Bytes captured so far in the current read word, newest at the top.
  logic [23:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] word_next;
  logic [16:0] poll_inc;
  logic [1:0]  cnt_inc;
  logic        poll_hit;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    op_d        = op_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    we_d        = 1'b0;
    addr_d      = 7'd0;
    data_out_d  = 8'd0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    word_next = {data_in, rdata_q};
    poll_inc  = {1'b0, poll_cnt_q} + 17'd1;
    cnt_inc   = byte_cnt_q + 2'd1;
    poll_hit  = (word_next & wdata_q) != 32'd0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d       = req_op;
          waddr_d    = req_addr[6:2];
          byte_cnt_d = 2'd0;
          poll_cnt_d = 16'd0;
          rdata_d    = 24'd0;
          wdata_d    = req_wdata;
          case (req_op)
            OpWrite: begin
              // Most significant byte first so a byte-0 start trigger sees the whole word.
              state_d    = StWr;
              we_d       = 1'b1;
              addr_d     = {req_addr[6:2], 2'b11};
              data_out_d = req_wdata[31:24];
              wdata_d    = {req_wdata[23:0], 8'h00};
            end
            OpRead, OpPoll: begin
              state_d = StRd;
              addr_d  = {req_addr[6:2], 2'b00};
            end
            default: begin
              state_d     = StRsp;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = 32'd0;
            end
          endcase
        end
      end

      StWr: begin
        if (byte_cnt_q == 2'd3) begin
          state_d     = StRsp;
          byte_cnt_d  = 2'd0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'd0;
        end else begin
          byte_cnt_d = cnt_inc;
          we_d       = 1'b1;
          addr_d     = {waddr_q, ~cnt_inc};
          data_out_d = wdata_q[31:24];
          wdata_d    = {wdata_q[23:0], 8'h00};
        end
      end

      StRd: begin
        rdata_d = word_next[31:8];
        if (byte_cnt_q != 2'd3) begin
          byte_cnt_d = cnt_inc;
          addr_d     = {waddr_q, cnt_inc};
        end else begin
          // Word complete: the poll decision is made here so a final iteration
          // goes straight to the response; CHK is only the gap before a retry.
          byte_cnt_d = 2'd0;
          if (op_q == OpRead || poll_hit) begin
            state_d     = StRsp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = word_next;
          end else begin
            poll_cnt_d = poll_inc[15:0];
            if (poll_inc == 17'(POLL_MAX)) begin
              state_d     = StRsp;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = word_next;
            end else begin
              state_d = StChk;
            end
          end
        end
      end

      StChk: begin
        state_d = StRd;
        rdata_d = 24'd0;
        addr_d  = {waddr_q, 2'b00};
      end

      StRsp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      byte_cnt_q  <= 2'd0;
      poll_cnt_q  <= 16'd0;
      op_q        <= OpWrite;
      waddr_q     <= 5'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 24'd0;
      we_q        <= 1'b0;
      addr_q      <= 7'd0;
      data_out_q  <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      op_q        <= op_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign data_out  = data_out_q;

endmodule
